// File: rtl/mem_port_sequencer.sv
// Shares one single-port 16-bit word memory between fetch and load/store, splitting odd byte addresses into two word accesses.
// Optional access statistics are enabled with `define MEM_PORT_SEQUENCER_STATS_EN.
module mem_port_sequencer #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        busy,
  output logic [14:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] stat_misaligned,
  output logic [15:0] stat_fetch_wait
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = 15;
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  state_t          state, state_nxt;
  logic            sel_f_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   lo_q;
  logic [SW-1:0]   starve_cnt;
  logic            starved;
  logic            grant_d;
  logic            grant_f;
  logic            accept;
  logic            acc_we;
  logic            acc_odd;
  logic            odd_q;
  logic [WW-1:0]   w0;
  logic [WW-1:0]   w1;
  logic [DW-1:0]   rdata_c;

  // Fetch is forced through once data has won STARVE_MAX times in a row.
  assign starved = (STARVE_MAX != 0) && f_req && (starve_cnt == SW'(STARVE_MAX));
  assign grant_d = (state == IDLE) && d_req && !starved;
  assign grant_f = (state == IDLE) && f_req && !grant_d;
  assign accept  = grant_d | grant_f;
  assign acc_we  = grant_d & d_we;
  assign acc_odd = grant_d ? d_addr[0] : f_addr[0];

  assign odd_q = addr_q[0];
  assign w0    = addr_q[AW-1:1];
  assign w1    = WW'(w0 + WW'(1));
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request capture at acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_f_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      sel_f_q <= 1'b0;
      we_q    <= d_we;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
    end else if (grant_f) begin
      sel_f_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= f_addr;
      wdata_q <= '0;
    end
  end

  // Low word of a misaligned read arrives during RD1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lo_q <= '0;
    else if (state == RD1)  lo_q <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_f || !f_req)
        starve_cnt <= '0;
      else if (grant_d && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= SW'(starve_cnt + SW'(1));
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    f_rdata   = '0;
    d_rdata   = '0;
    rdata_c   = odd_q ? {mem_rdata[7:0], lo_q[15:8]} : mem_rdata;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (acc_we && !acc_odd) ? WR0 : RD0;
      end
      RD0: begin
        mem_addr  = w0;
        mem_rd_en = 1'b1;
        if (we_q)       state_nxt = WR0;
        else if (odd_q) state_nxt = RD1;
        else            state_nxt = DONE;
      end
      RD1: begin
        mem_addr  = w1;
        mem_rd_en = 1'b1;
        state_nxt = we_q ? WR1 : DONE;
      end
      WR0: begin
        mem_addr  = w0;
        mem_wr_en = 1'b1;
        mem_wdata = odd_q ? {wdata_q[7:0], mem_rdata[7:0]} : wdata_q;
        state_nxt = odd_q ? RD1 : DONE;
      end
      WR1: begin
        mem_addr  = w1;
        mem_wr_en = 1'b1;
        mem_wdata = {mem_rdata[15:8], wdata_q[15:8]};
        state_nxt = DONE;
      end
      DONE: begin
        if (sel_f_q) begin
          f_ack   = 1'b1;
          f_rdata = rdata_c;
        end else begin
          d_ack   = 1'b1;
          d_rdata = we_q ? '0 : rdata_c;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_PORT_SEQUENCER_STATS_EN
  logic [15:0] stat_mis_q;
  logic [15:0] stat_fw_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_mis_q <= '0;
      stat_fw_q  <= '0;
    end else begin
      if (accept && acc_odd && (stat_mis_q != 16'hFFFF))
        stat_mis_q <= 16'(stat_mis_q + 16'd1);
      if (f_req && !f_ack && (stat_fw_q != 16'hFFFF))
        stat_fw_q <= 16'(stat_fw_q + 16'd1);
    end
  end

  assign stat_misaligned = stat_mis_q;
  assign stat_fetch_wait = stat_fw_q;
`else
  assign stat_misaligned = '0;
  assign stat_fetch_wait = '0;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: vector table with a scoreboard, plus arbitration, wrap and reset-abort sequences.
`timescale 1ns/1ps
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;

  logic        f_ack, d_ack, busy, mem_rd_en, mem_wr_en;
  logic [15:0] f_rdata, d_rdata, mem_wdata, mem_rdata, stat_misaligned, stat_fetch_wait;
  logic [14:0] mem_addr;

  logic        b_f_ack, b_d_ack, b_busy, b_mem_rd_en, b_mem_wr_en;
  logic [15:0] b_f_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata, b_stat_mis, b_stat_fw;
  logic [14:0] b_mem_addr;
  assign b_mem_rdata = 16'h0000;

  always #5 clk = ~clk;

  mem_port_sequencer #(.STARVE_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_misaligned(stat_misaligned), .stat_fetch_wait(stat_fetch_wait)
  );

  mem_port_sequencer #(.STARVE_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(b_f_ack), .f_rdata(b_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .busy(b_busy),
    .mem_addr(b_mem_addr), .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .stat_misaligned(b_stat_mis), .stat_fetch_wait(b_stat_fw)
  );

  // Memory model with backdoor write port and an access log.
  logic [15:0] mem [0:32767];
  logic        bk_we = 1'b0;
  logic [14:0] bk_addr = '0;
  logic [15:0] bk_data = '0;
  typedef struct packed { logic wr; logic [14:0] addr; } op_t;
  op_t op_log[$];
  int  both_viol = 0;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_rd_en || mem_wr_en) op_log.push_back({mem_wr_en, mem_addr});
    if (mem_rd_en && mem_wr_en) both_viol++;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bk_write(input logic [14:0] a, input logic [15:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  task automatic init_mem();
    bk_write(15'h0010, 16'h1234);
    bk_write(15'h0011, 16'h5678);
    bk_write(15'h0012, 16'h00EF);
    bk_write(15'h7FFF, 16'hAA00);
    bk_write(15'h0000, 16'h00BB);
  endtask

  typedef struct {
    bit          is_f;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          lat;
    int          ops_n;
    logic [3:0]  wr_mask;
    logic [3:0]  hi_mask;
    logic [15:0] m10;
    logic [15:0] m11;
  } vec_t;

  typedef struct { bit is_f; logic [15:0] rdata; int lat; } exp_t;
  exp_t sb[$];

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    int base;
    bit got;
    exp_t e;
    op_t op;
    logic [14:0] w0, w1;
    init_mem();
    base = op_log.size();
    w0 = v.addr[15:1];
    w1 = 15'(w0 + 15'd1);
    sb.push_back('{v.is_f, v.exp_rdata, v.lat});
    if (v.is_f) begin
      f_req = 1'b1; f_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    @(posedge clk); #1;
    f_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata;
    lat = 1; got = 1'b0;
    while (!got && lat < 12) begin
      if (f_ack || d_ack) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    check({nm, " ack_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      check({nm, " latency"}, lat, e.lat);
      check({nm, " ack_sel"}, {30'd0, f_ack, d_ack}, e.is_f ? 32'd2 : 32'd1);
      check({nm, " rdata"}, 32'(e.is_f ? f_rdata : d_rdata), 32'(e.rdata));
      check({nm, " other_rdata"}, 32'(e.is_f ? d_rdata : f_rdata), 32'd0);
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    check({nm, " idle_after"}, 32'(busy), 32'd0);
    check({nm, " op_count"}, op_log.size() - base, v.ops_n);
    for (int i = 0; i < v.ops_n && base + i < op_log.size(); i++) begin
      op = op_log[base + i];
      check({nm, $sformatf(" op%0d_wr", i)}, 32'(op.wr), 32'(v.wr_mask[i]));
      check({nm, $sformatf(" op%0d_addr", i)}, 32'(op.addr), 32'(v.hi_mask[i] ? w1 : w0));
    end
    check({nm, " mem10"}, 32'(mem[15'h0010]), 32'(v.m10));
    check({nm, " mem11"}, 32'(mem[15'h0011]), 32'(v.m11));
  endtask

  vec_t vecs [8];
  int   ord [3];

  initial begin
    int n, cyc, bfa, bda;
    bit saw_ack;

    vecs[0] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h7812, 3, 2, 4'b0000, 4'b0010, 16'h1234, 16'h5678};
    vecs[1] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 2, 1, 4'b0000, 4'b0000, 16'h1234, 16'h5678};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 2, 1, 4'b0000, 4'b0000, 16'h1234, 16'h5678};
    vecs[3] = '{1'b0, 1'b0, 16'h0023, 16'h0000, 16'hEF56, 3, 2, 4'b0000, 4'b0010, 16'h1234, 16'h5678};
    vecs[4] = '{1'b0, 1'b1, 16'h0021, 16'hABCD, 16'h0000, 5, 4, 4'b1010, 4'b1100, 16'hCD34, 16'h56AB};
    vecs[5] = '{1'b0, 1'b1, 16'h0022, 16'h1111, 16'h0000, 2, 1, 4'b0001, 4'b0000, 16'h1234, 16'h1111};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hBBAA, 3, 2, 4'b0000, 4'b0010, 16'h1234, 16'h5678};
    vecs[7] = '{1'b0, 1'b0, 16'h0021, 16'h0000, 16'h7812, 3, 2, 4'b0000, 4'b0010, 16'h1234, 16'h5678};

    #12;
    check("reset_ctrl", {27'd0, f_ack, d_ack, busy, mem_rd_en, mem_wr_en}, 32'd0);
    check("reset_bus", {1'b0, mem_addr, mem_wdata}, 32'd0);
    check("reset_rdata", {f_rdata, d_rdata}, 32'd0);
    check("reset_stats", {stat_misaligned, stat_fetch_wait}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
`ifdef MEM_PORT_SEQUENCER_STATS_EN
        check("stat_misaligned", 32'(stat_misaligned), 32'd1);
        check("stat_fetch_wait", 32'(stat_fetch_wait), 32'd3);
`else
        check("stat_misaligned_tied", 32'(stat_misaligned), 32'd0);
        check("stat_fetch_wait_tied", 32'(stat_fetch_wait), 32'd0);
`endif
      end
    end

    // Both requesters at once with data held: STARVE_MAX=2 gives data, data, fetch.
    repeat (2) @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    f_req = 1'b1; f_addr = 16'h0022;
    n = 0; cyc = 0; bfa = 0; bda = 0;
    while (n < 3 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (b_f_ack && d_req) bfa++;
      if (b_d_ack) bda++;
      if (f_ack)      begin ord[n] = 1; n++; end
      else if (d_ack) begin ord[n] = 0; n++; end
    end
    d_req = 1'b0; f_req = 1'b0;
    check("starve_acks", n, 3);
    if (n == 3) begin
      check("starve_grant0", ord[0], 0);
      check("starve_grant1", ord[1], 0);
      check("starve_grant2", ord[2], 1);
    end
    check("strict_no_fetch", bfa, 0);
    check("strict_data_served", 32'(bda >= 2), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Reset during WR1 of a misaligned store.
    init_mem();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0021; d_wdata = 16'hABCD;
    saw_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      saw_ack |= d_ack;
    end
    check("abort_in_wr1", {30'd0, mem_wr_en, mem_rd_en}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {27'd0, f_ack, d_ack, busy, mem_rd_en, mem_wr_en}, 32'd0);
    check("abort_bus", {1'b0, mem_addr, mem_wdata}, 32'd0);
    check("abort_rdata", {f_rdata, d_rdata}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      saw_ack |= d_ack;
    end
    check("abort_no_ack", 32'(saw_ack), 32'd0);
    check("abort_mem10", 32'(mem[15'h0010]), 32'h0000CD34);
    check("abort_mem11", 32'(mem[15'h0011]), 32'h00005678);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("rd_wr_exclusive", both_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Arbitrates one single-port, word-addressed 16-bit memory between two requesters: the instruction-fetch requester (read-only) and the load/store requester.
- Every 16-bit access uses a byte address, and that address may be odd.
- Odd addresses are split into two aligned word accesses. Stores to odd addresses use read-modify-write.
- Sits between the CPU pipeline and the memory, so the core no longer needs a dual-port memory.

Parameters:
- STARVE_MAX, 4, number of consecutive data grants allowed while a fetch is pending before fetch is forced through; 0 = strict data priority.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  16  fetch byte address.
- f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle.
- f_rdata  out  16  fetched halfword.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  16  data byte address.
- d_wdata  in  16  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
- d_rdata  out  16  load data; 0 for stores.
- busy  out  1  state != IDLE.
- mem_addr  out  15  word address to memory.
- mem_rd_en  out  1  read strobe.
- mem_wr_en  out  1  write strobe; the write commits at posedge.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  synchronous read data, valid the cycle after mem_rd_en.
- stat_misaligned  out  16  see Optional Feature.
- stat_fetch_wait  out  16  see Optional Feature.

Behaviour:
- Byte order is little-endian. Word w0 = addr[15:1]; w1 = (w0 + 1) mod 2^15, so 0x7FFF wraps to 0x0000.
- Misaligned load result = {mem[w1][7:0], mem[w0][15:8]}.
- Misaligned store: mem[w0][15:8] <= wdata[7:0]; mem[w1][7:0] <= wdata[15:8]. The other byte of each word is preserved.
- States: IDLE, RD0, RD1, WR0, WR1, DONE. A request is accepted at the IDLE posedge. At acceptance the block latches requester id, we, addr and wdata; later changes on the inputs are ignored.
- Arbitration in IDLE:
  - Data wins by default.
  - Fetch wins if f_req=1 and starve_cnt == STARVE_MAX, with STARVE_MAX != 0.
  - starve_cnt increments on each data grant made while f_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on a fetch grant, or on any IDLE cycle with f_req=0.
- Aligned load/fetch: IDLE -> RD0 (rd w0) -> DONE (rdata = mem_rdata). Ack falls in the 2nd cycle after acceptance.
- Misaligned load/fetch: IDLE -> RD0 (rd w0) -> RD1 (lo_q <= mem_rdata; rd w1) -> DONE (rdata = {mem_rdata[7:0], lo_q[15:8]}). Ack falls in the 3rd cycle.
- Aligned store: IDLE -> WR0 (wr w0 = wdata) -> DONE. Ack falls in the 2nd cycle.
- Misaligned store: IDLE -> RD0 -> WR0 (wr w0 = {wdata[7:0], mem_rdata[7:0]}) -> RD1 -> WR1 (wr w1 = {mem_rdata[15:8], wdata[15:8]}) -> DONE. Ack falls in the 5th cycle.
- DONE:
  - Exactly one of f_ack/d_ack is high, selected by the latched requester.
  - f_rdata/d_rdata are driven only during their ack cycle and are 0 otherwise.
  - DONE always goes to IDLE. A new request is accepted no earlier than the cycle after DONE, so there is one idle bubble per access.
- mem_* outputs are a combinational decode of state and latched request. All are 0 in IDLE and DONE. mem_rd_en and mem_wr_en are never high together.
- Reset values: state=IDLE; acks, rdata, busy, mem_* and starve_cnt all 0; lo_q=0.
- Reset mid-operation aborts immediately: no ack and no further memory writes. A misaligned store aborted after WR0 leaves w0 updated and w1 untouched; this is accepted behaviour.
- A fetch request with its address in the pending data store's range is not detected. Coherence with self-modifying code is the pipeline's responsibility.

Optional Feature:
- Macro: MEM_PORT_SEQUENCER_STATS_EN.
- Defined:
  - stat_misaligned counts accepted odd-address requests from both requesters.
  - stat_fetch_wait counts cycles with f_req=1 and no f_ack.
  - Both counters are 16-bit, saturating at 0xFFFF, and reset to 0 by rst_n.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Memory init for all scenarios: mem[0x10]=0x1234, mem[0x11]=0x5678.
- Load at d_addr=0x0020 -> d_rdata=0x1234 with d_ack in the 2nd cycle after acceptance; exactly one mem_rd_en cycle, to 0x10.
- Fetch at f_addr=0x0021 -> f_rdata=0x7812 with f_ack in the 3rd cycle; reads to 0x10 then 0x11.
- Store at d_addr=0x0021, d_wdata=0xABCD -> mem[0x10]=0xCD34, mem[0x11]=0x56AB; d_ack in the 5th cycle; ordering rd, wr, rd, wr.
- f_req and d_req raised in the same cycle, STARVE_MAX=2, d_req held continuously -> grant order data, data, fetch.
- With STARVE_MAX=0 and the same stimulus, fetch never granted while d_req=1.
- Load at 0xFFFF with mem[0x7FFF]=0xAA00, mem[0x0000]=0x00BB -> d_rdata=0xBBAA.
- Reset asserted during WR1 of the 0x0021 store -> no d_ack, mem[0x10]=0xCD34, mem[0x11]=0x5678, all outputs 0.
- With MEM_PORT_SEQUENCER_STATS_EN defined, after the misaligned fetch -> stat_misaligned=1, stat_fetch_wait=3.
